port_tx_drain: RTL and testbench
================================

// Module: port_tx_drain
// PURPOSE
//  Read side of one switch output-port fifo. Pops words with the fifo's 1-cycle read latency,
//  prefetches them into a 3-entry output buffer and sends packets on a valid/ready tx interface
//  with sop/eop framing. One instance per output port, between the fifo and the port pins.
// PARAMETERS
//  W_WIDTH   32  word width; must equal the attached fifo's W_WIDTH
//  LEN_W     8   width of the header length field, header bits [LEN_W-1:0]
//  CNT_W     16  width of the delivered-packet counter
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        reset, asynchronous, active-low (polarity/synchronicity fixed)
//  fifo_rd_en   out  1        pop request to fifo
//  fifo_data    in   W_WIDTH  fifo data_out; valid the cycle after an accepted pop, else 0
//  fifo_empty   in   1        fifo empty flag (registered in the fifo)
//  tx_en        in   1        permit start of a new packet (sampled only at a packet boundary)
//  tx_valid     out  1        tx word valid
//  tx_data      out  W_WIDTH  tx word
//  tx_sop       out  1        tx word is a packet header
//  tx_eop       out  1        tx word is the last word of its packet
//  tx_ready     in   1        sink accepts; transfer = tx_valid & tx_ready at posedge clk
//  pkt_done     out  1        one-cycle pulse, cycle after an eop transfer
//  pkt_cnt      out  CNT_W    packets delivered, wraps 2^CNT_W-1 -> 0
//  busy         out  1        state==PAYLOAD or buffer/in-flight non-empty
// BEHAVIOUR
//  Reset: all outputs 0; buffer cleared; inflight=0; state=HDR. Async clear at any time;
//   words in flight or buffered are discarded (the fifo shares rst_n).
//  Packet: header word with N = hdr[LEN_W-1:0], then N payload words. N=0 gives a 1-word packet
//   with sop=eop=1. The header is forwarded unmodified.
//  Pop: fifo_rd_en = !fifo_empty && (occ + inflight < 3), from registers only (no tx_ready path).
//   inflight <= fifo_rd_en. When inflight==1, fifo_data is written into the buffer at the next edge.
//  Latency: fifo_empty falls after edge E0 -> rd_en high -> data popped at E1 -> captured at E2.
//   tx_valid goes high after E2 when tx_en=1 (state HDR) or state=PAYLOAD.
//  Throughput: with tx_ready held 1, 1 word/cycle sustained.
//  The buffer never overflows: occ + inflight <= 3 is an invariant, checked by assertion.
//  Simultaneous capture and transfer in one cycle: occ unchanged; order is preserved.
//  FSM (advances on output-side transfers):
//   HDR:     tx_valid = occ>0 && tx_en; sop=1; eop=(N==0).
//            On transfer: N==0 -> stay in HDR and pulse pkt_done; else rem<=N, go to PAYLOAD.
//   PAYLOAD: tx_valid = occ>0; sop=0; eop=(rem==1).
//            On transfer: rem<=rem-1; if rem==1, go to HDR and pulse pkt_done.
//  tx_en low never cuts a packet short; it only holds a header. Prefetch continues while held.
//  tx_valid, once high, stays high until transfer. tx_data/sop/eop stay stable while stalled.
//  tx_data is the buffer head (registered storage). Outputs with tx_valid=0 are 0.
//  pkt_cnt increments on the eop transfer cycle, in step with pkt_done.
// STRUCTURE
//  Shared package: typedef state_e {HDR, PAYLOAD}; localparams OUT_BUF_DEPTH=3 and LEN_LSB=0.
//  The fifo's W_WIDTH default also lives in this package.
//  Sub-module tx_out_buf: 3-entry circular buffer holding data and occupancy (push/pop/head).
//  The FSM, pop logic and counters sit in the top level.
// TESTING
//  1 fifo gets 0x0000_0002, 0xA, 0xB; tx_ready=1, tx_en=1 -> 3 beats on consecutive cycles.
//    Beat 1 = header, sop=1, first tx_valid 2 cycles after empty falls. Beat 3 is 0xB with eop=1.
//    pkt_done pulses once, pkt_cnt=1.
//  2 header 0x0000_0000 -> single beat with sop=eop=1; FSM stays in HDR; pkt_cnt increments.
//  3 N=4 packet, tx_ready toggling 1,0,0,1,...
//    -> tx_data held stable during stalls; occ+inflight <= 3; fifo_rd_en low while buffer full.
//  4 tx_en=0 with 2 packets queued -> tx_valid=0, buffer fills to 3, fifo_rd_en=0.
//    tx_en=1 -> both packets delivered in order with no gap.
//    Dropping tx_en mid-packet does not stall the payload.
//  5 rst_n low mid-PAYLOAD (rem=3) -> outputs 0 at once; after release a new header gets sop=1.
//  6 pkt_cnt preloaded near 0xFFFF (CNT_W=16), 2 packets sent -> reads 0xFFFF, then 0x0000.

Source files
------------

// File: rtl/port_tx_drain_pkg.sv
// Shared types and constants for the output-port drain logic.
package port_tx_drain_pkg;

    typedef enum logic {
        HDR     = 1'b0,
        PAYLOAD = 1'b1
    } state_e;

    localparam int OUT_BUF_DEPTH = 3;
    localparam int LEN_LSB       = 0;
    localparam int W_WIDTH_DEF   = 32;

endpackage

// File: rtl/port_tx_drain_out_buf.sv
// Three-entry circular buffer between the fifo read port and the tx interface.
module tx_out_buf
    import port_tx_drain_pkg::*;
#(
    parameter int DATA_W = W_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] mem [OUT_BUF_DEPTH];
    logic [1:0]        rd_ptr;
    logic [1:0]        wr_ptr;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(OUT_BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            occ    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/port_tx_drain.sv
// Read side of one output-port fifo: prefetch into a small buffer, frame packets on tx.
module port_tx_drain
    import port_tx_drain_pkg::*;
#(
    parameter int W_WIDTH = W_WIDTH_DEF,
    parameter int LEN_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               fifo_rd_en,
    input  logic [W_WIDTH-1:0] fifo_data,
    input  logic               fifo_empty,
    input  logic               tx_en,
    output logic               tx_valid,
    output logic [W_WIDTH-1:0] tx_data,
    output logic               tx_sop,
    output logic               tx_eop,
    input  logic               tx_ready,
    output logic               pkt_done,
    output logic [CNT_W-1:0]   pkt_cnt,
    output logic               busy
);

    state_e             state, state_nx;
    logic [LEN_W-1:0]   rem, rem_nx;
    logic               hdr_hold, hold_nx;
    logic               inflight;
    logic               done_nx;
    logic               valid_c, sop_c, eop_c, xfer;
    logic [1:0]         occ;
    logic [W_WIDTH-1:0] head;
    logic [LEN_W-1:0]   hdr_len;

    tx_out_buf #(.DATA_W(W_WIDTH)) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (fifo_data),
        .pop       (xfer),
        .head      (head),
        .occ       (occ)
    );

    assign hdr_len = head[LEN_LSB +: LEN_W];

    // Counting in-flight pops keeps the buffer from ever overflowing.
    assign fifo_rd_en = !fifo_empty &&
                        (({1'b0, occ} + {2'b00, inflight}) < 3'(OUT_BUF_DEPTH));

    always_comb begin
        valid_c  = 1'b0;
        sop_c    = 1'b0;
        eop_c    = 1'b0;
        state_nx = state;
        rem_nx   = rem;
        hold_nx  = hdr_hold;
        done_nx  = 1'b0;
        case (state)
            HDR: begin
                // hdr_hold keeps a presented header valid if tx_en drops while stalled
                valid_c = (occ != 2'd0) && (tx_en || hdr_hold);
                sop_c   = 1'b1;
                eop_c   = (hdr_len == '0);
                if (valid_c && tx_ready) begin
                    hold_nx = 1'b0;
                    if (hdr_len == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        rem_nx   = hdr_len;
                        state_nx = PAYLOAD;
                    end
                end else if (valid_c) begin
                    hold_nx = 1'b1;
                end
            end
            PAYLOAD: begin
                valid_c = (occ != 2'd0);
                eop_c   = (rem == LEN_W'(1));
                if (valid_c && tx_ready) begin
                    rem_nx = rem - LEN_W'(1);
                    if (rem == LEN_W'(1)) begin
                        state_nx = HDR;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = HDR;
        endcase
    end

    assign xfer     = valid_c && tx_ready;
    assign tx_valid = valid_c;
    assign tx_data  = valid_c ? head : '0;
    assign tx_sop   = valid_c && sop_c;
    assign tx_eop   = valid_c && eop_c;
    assign busy     = (state == PAYLOAD) || (occ != 2'd0) || inflight;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HDR;
            rem      <= '0;
            hdr_hold <= 1'b0;
            inflight <= 1'b0;
            pkt_done <= 1'b0;
            pkt_cnt  <= '0;
        end else begin
            state    <= state_nx;
            rem      <= rem_nx;
            hdr_hold <= hold_nx;
            inflight <= fifo_rd_en;
            pkt_done <= done_nx;
            pkt_cnt  <= pkt_cnt + CNT_W'(done_nx);
        end
    end

    occ_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
        (({1'b0, occ} + {2'b00, inflight}) <= 3'(OUT_BUF_DEPTH)));

endmodule

// File: tb/tb_port_tx_drain.sv
// Directed bench for port_tx_drain with a behavioural fifo and a tx-side monitor.
module tb_port_tx_drain;

    localparam int W  = 32;
    localparam int LW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_rd_en;
    logic [W-1:0]  fifo_data = '0;
    logic          fifo_empty = 1'b1;
    logic          tx_en = 1'b0;
    logic          tx_valid;
    logic [W-1:0]  tx_data;
    logic          tx_sop;
    logic          tx_eop;
    logic          tx_ready = 1'b0;
    logic          pkt_done;
    logic [CW-1:0] pkt_cnt;
    logic          busy;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_pop   = 0;
    int            n_xfer  = 0;
    logic [W-1:0]  fifo_q[$];
    logic [W+1:0]  rx_q[$];

    port_tx_drain #(.W_WIDTH(W), .LEN_W(LW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .tx_en      (tx_en),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_sop     (tx_sop),
        .tx_eop     (tx_eop),
        .tx_ready   (tx_ready),
        .pkt_done   (pkt_done),
        .pkt_cnt    (pkt_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Fifo model with 1-cycle read latency and registered empty, plus tx monitor.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q.delete();
            fifo_data  <= '0;
            fifo_empty <= 1'b1;
            n_pop  = 0;
            n_xfer = 0;
        end else begin
            if (tx_valid && tx_ready) begin
                rx_q.push_back({tx_sop, tx_eop, tx_data});
                n_xfer++;
            end
            if (fifo_rd_en && fifo_q.size() > 0) begin
                fifo_data <= fifo_q.pop_front();
                n_pop++;
            end else begin
                fifo_data <= '0;
            end
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_occ();
        int o;
        o = n_pop - n_xfer;
        check_eq("occ_le3", 64'(o <= 3), 64'd1);
        if (o == 3) check_eq("rd_en_full", 64'(fifo_rd_en), 64'd0);
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            step();
            chk_occ();
            k++;
        end
        check_eq(tag, 64'(rx_q.size()), 64'(n));
    endtask

    task automatic chk_rx(input string tag, input int idx, input logic [W+1:0] exp);
        logic [63:0] act;
        act = (idx < rx_q.size()) ? 64'(rx_q[idx]) : '1;
        check_eq(tag, act, 64'(exp));
    endtask

    task automatic chk_out(input string tag, input logic v, input logic s, input logic e,
                           input logic [W-1:0] d);
        check_eq({tag, "_v"}, 64'(tx_valid), 64'(v));
        check_eq({tag, "_beat"}, 64'({tx_sop, tx_eop, tx_data}), 64'({s, e, d}));
    endtask

    initial begin
        logic [W+1:0] held;
        logic         stalled;
        logic [W+1:0] exp4 [5];
        int           k;

        // reset state
        step();
        check_eq("rst_valid", 64'(tx_valid), 64'd0);
        check_eq("rst_data", 64'(tx_data), 64'd0);
        check_eq("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check_eq("rst_cnt", 64'(pkt_cnt), 64'd0);
        check_eq("rst_misc", 64'({tx_sop, tx_eop, pkt_done, busy}), 64'd0);
        rst_n = 1'b1;
        step();

        // 1: header N=2 with two payload words, full rate
        tx_en = 1'b1; tx_ready = 1'b1;
        fifo_q.push_back(32'h0000_0002);
        fifo_q.push_back(32'h0000_000A);
        fifo_q.push_back(32'h0000_000B);
        step();
        check_eq("t1_rd_en", 64'(fifo_rd_en), 64'd1);
        check_eq("t1_nv0", 64'(tx_valid), 64'd0);
        step();
        check_eq("t1_nv1", 64'(tx_valid), 64'd0);
        step(); chk_out("t1_b1", 1'b1, 1'b1, 1'b0, 32'h2);
        step(); chk_out("t1_b2", 1'b1, 1'b0, 1'b0, 32'hA);
        step(); chk_out("t1_b3", 1'b1, 1'b0, 1'b1, 32'hB);
        step();
        check_eq("t1_idle", 64'(tx_valid), 64'd0);
        check_eq("t1_done", 64'(pkt_done), 64'd1);
        check_eq("t1_cnt", 64'(pkt_cnt), 64'd1);
        check_eq("t1_busy", 64'(busy), 64'd0);
        step();
        check_eq("t1_done_pulse", 64'(pkt_done), 64'd0);

        // 2: single-word packets, upper header bits ignored for length
        fifo_q.push_back(32'h0000_0000);
        fifo_q.push_back(32'hABCD_0100);
        step(); step(); step();
        chk_out("t2_b1", 1'b1, 1'b1, 1'b1, 32'h0);
        step();
        chk_out("t2_b2", 1'b1, 1'b1, 1'b1, 32'hABCD_0100);
        check_eq("t2_done1", 64'(pkt_done), 64'd1);
        check_eq("t2_cnt1", 64'(pkt_cnt), 64'd2);
        step();
        check_eq("t2_done2", 64'(pkt_done), 64'd1);
        check_eq("t2_cnt2", 64'(pkt_cnt), 64'd3);
        check_eq("t2_idle", 64'({tx_valid, busy}), 64'd0);

        // 3: N=4 with tx_ready 1,0,0 repeating
        rx_q.delete();
        fifo_q.push_back(32'h0000_0004);
        fifo_q.push_back(32'h11); fifo_q.push_back(32'h22);
        fifo_q.push_back(32'h33); fifo_q.push_back(32'h44);
        stalled = 1'b0; held = '0; k = 0;
        while (rx_q.size() < 5 && k < 60) begin
            if (stalled) begin
                check_eq("t3_hold_v", 64'(tx_valid), 64'd1);
                check_eq("t3_hold_d", 64'({tx_sop, tx_eop, tx_data}), 64'(held));
            end
            tx_ready = (k % 3 == 0);
            #1;
            stalled = tx_valid && !tx_ready;
            held = {tx_sop, tx_eop, tx_data};
            step();
            chk_occ();
            k++;
        end
        tx_ready = 1'b1;
        check_eq("t3_count", 64'(rx_q.size()), 64'd5);
        chk_rx("t3_r0", 0, {1'b1, 1'b0, 32'h4});
        chk_rx("t3_r1", 1, {1'b0, 1'b0, 32'h11});
        chk_rx("t3_r2", 2, {1'b0, 1'b0, 32'h22});
        chk_rx("t3_r3", 3, {1'b0, 1'b0, 32'h33});
        chk_rx("t3_r4", 4, {1'b0, 1'b1, 32'h44});
        step();
        check_eq("t3_cnt", 64'(pkt_cnt), 64'd4);

        // 4: tx_en low holds headers while the buffer fills
        tx_en = 1'b0;
        fifo_q.push_back(32'h1); fifo_q.push_back(32'hC1);
        fifo_q.push_back(32'h2); fifo_q.push_back(32'hD1); fifo_q.push_back(32'hD2);
        repeat (8) begin step(); chk_occ(); end
        check_eq("t4_nv", 64'(tx_valid), 64'd0);
        check_eq("t4_ndata", 64'(tx_data), 64'd0);
        check_eq("t4_rd_en", 64'(fifo_rd_en), 64'd0);
        check_eq("t4_full", 64'(n_pop - n_xfer), 64'd3);
        check_eq("t4_busy", 64'(busy), 64'd1);
        exp4[0] = {1'b1, 1'b0, 32'h1};
        exp4[1] = {1'b0, 1'b1, 32'hC1};
        exp4[2] = {1'b1, 1'b0, 32'h2};
        exp4[3] = {1'b0, 1'b0, 32'hD1};
        exp4[4] = {1'b0, 1'b1, 32'hD2};
        tx_en = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_eq("t4_gap", 64'(tx_valid), 64'd1);
            check_eq("t4_beat", 64'({tx_sop, tx_eop, tx_data}), 64'(exp4[i]));
            if (i == 3) tx_en = 1'b0;
            step();
        end
        check_eq("t4_cnt", 64'(pkt_cnt), 64'd6);
        check_eq("t4_idle", 64'(tx_valid), 64'd0);
        tx_en = 1'b1;

        // 5: async reset in the middle of a payload
        rx_q.delete();
        fifo_q.push_back(32'h5);
        for (int i = 1; i <= 5; i++) fifo_q.push_back(32'h50 + 32'(i));
        wait_rx("t5_pre", 3, 20);
        tx_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_v", 64'(tx_valid), 64'd0);
        check_eq("t5_rst_d", 64'(tx_data), 64'd0);
        check_eq("t5_rst_se", 64'({tx_sop, tx_eop}), 64'd0);
        check_eq("t5_rst_rd", 64'(fifo_rd_en), 64'd0);
        check_eq("t5_rst_cnt", 64'(pkt_cnt), 64'd0);
        check_eq("t5_rst_busy", 64'(busy), 64'd0);
        step(); step();
        rst_n = 1'b1;
        rx_q.delete();
        tx_ready = 1'b1;
        fifo_q.push_back(32'h1);
        fifo_q.push_back(32'h77);
        wait_rx("t5_post", 2, 20);
        chk_rx("t5_r0", 0, {1'b1, 1'b0, 32'h1});
        chk_rx("t5_r1", 1, {1'b0, 1'b1, 32'h77});
        step();
        check_eq("t5_cnt", 64'(pkt_cnt), 64'd1);

        // 6: counter wrap; bring pkt_cnt to 0xFFFE with one-word packets
        rx_q.delete();
        for (int i = 0; i < 65533; i++) fifo_q.push_back({16'(i), 16'h0000});
        k = 0;
        while (pkt_cnt != 16'hFFFE && k < 70000) begin
            step();
            k++;
        end
        check_eq("t6_pre", 64'(pkt_cnt), 64'hFFFE);
        rx_q.delete();
        fifo_q.push_back(32'h0);
        fifo_q.push_back(32'h1);
        fifo_q.push_back(32'h99);
        step();
        k = 0;
        while (!pkt_done && k < 20) begin step(); k++; end
        check_eq("t6_ffff", 64'(pkt_cnt), 64'hFFFF);
        step();
        k = 0;
        while (!pkt_done && k < 20) begin step(); k++; end
        check_eq("t6_wrap", 64'(pkt_cnt), 64'h0000);
        chk_rx("t6_last", 2, {1'b0, 1'b1, 32'h99});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
